tmds_slot_scheduler: RTL and testbench

- Word-rate scheduler for one TMDS lane of the video controller; runs entirely in the bit-clock domain.
- Divides the bit clock into 10-bit word slots and picks one source per slot: pixel stream, aux packet stream, or a control token.
- Drives the chosen 10-bit word and a one-cycle load strobe to the lane's serializer.

---
 rtl/tmds_slot_scheduler.sv | 160 ++++++++++++++++
 tb/tb_tmds_slot_scheduler.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/tmds_slot_scheduler.sv
// TMDS lane word-slot scheduler: picks pixel, aux or control token per slot.
// Optional underrun event counter enabled by TMDS_SCHED_UNDERRUN_CNT_EN.
module tmds_slot_scheduler #(
    parameter int SLOT_LEN = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic [1:0] ctrl,
    input  logic       px_valid,
    input  logic [9:0] px_data,
    input  logic       px_last,
    output logic       px_ready,
    input  logic       aux_valid,
    input  logic [9:0] aux_data,
    input  logic       aux_last,
    output logic       aux_ready,
    output logic [9:0] word,
    output logic       word_load,
    output logic [1:0] slot_src,
    output logic       underrun,
    input  logic       underrun_clr
`ifdef TMDS_SCHED_UNDERRUN_CNT_EN
    ,
    output logic [15:0] underrun_cnt
`endif
);

    localparam int CNT_W = $clog2(SLOT_LEN);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(SLOT_LEN - 1);

    localparam logic [1:0] SRC_CTRL = 2'b00;
    localparam logic [1:0] SRC_PX   = 2'b01;
    localparam logic [1:0] SRC_AUX  = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        VIDEO = 2'b01,
        AUX   = 2'b10
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             boundary;
    logic [9:0]       token;
    logic             ur_event;

    assign boundary = (cnt == LAST);

    always_comb begin
        token = 10'b1101010100;
        unique case (ctrl)
            2'b00: token = 10'b1101010100;
            2'b01: token = 10'b0010101011;
            2'b10: token = 10'b0101010100;
            2'b11: token = 10'b1010101011;
        endcase
    end

    // Grants only in the boundary cycle; a locked source is always ready.
    always_comb begin
        px_ready  = 1'b0;
        aux_ready = 1'b0;
        ur_event  = 1'b0;
        if (boundary) begin
            unique case (state)
                IDLE: begin
                    px_ready  = enable & px_valid;
                    aux_ready = enable & ~px_valid & aux_valid;
                end
                VIDEO: begin
                    px_ready = 1'b1;
                    ur_event = ~px_valid;
                end
                AUX: begin
                    aux_ready = 1'b1;
                    ur_event  = ~aux_valid;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt       <= '0;
            state     <= IDLE;
            word      <= 10'b1101010100;
            word_load <= 1'b0;
            slot_src  <= SRC_CTRL;
            underrun  <= 1'b0;
        end else begin
            cnt       <= boundary ? '0 : cnt + 1'b1;
            word_load <= boundary;
            if (ur_event) begin
                underrun <= 1'b1;
            end else if (underrun_clr) begin
                underrun <= 1'b0;
            end
            if (boundary) begin
                unique case (state)
                    IDLE: begin
                        if (px_ready) begin
                            word     <= px_data;
                            slot_src <= SRC_PX;
                            state    <= px_last ? IDLE : VIDEO;
                        end else if (aux_ready) begin
                            word     <= aux_data;
                            slot_src <= SRC_AUX;
                            state    <= aux_last ? IDLE : AUX;
                        end else begin
                            word     <= token;
                            slot_src <= SRC_CTRL;
                        end
                    end
                    VIDEO: begin
                        if (px_valid) begin
                            word     <= px_data;
                            slot_src <= SRC_PX;
                            if (px_last) state <= IDLE;
                        end else begin
                            word     <= token;
                            slot_src <= SRC_CTRL;
                            state    <= IDLE;
                        end
                    end
                    AUX: begin
                        if (aux_valid) begin
                            word     <= aux_data;
                            slot_src <= SRC_AUX;
                            if (aux_last) state <= IDLE;
                        end else begin
                            word     <= token;
                            slot_src <= SRC_CTRL;
                            state    <= IDLE;
                        end
                    end
                    default: begin
                        word     <= token;
                        slot_src <= SRC_CTRL;
                        state    <= IDLE;
                    end
                endcase
            end
        end
    end

`ifdef TMDS_SCHED_UNDERRUN_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            underrun_cnt <= '0;
        end else if (underrun_clr) begin
            underrun_cnt <= ur_event ? 16'd1 : 16'd0;
        end else if (ur_event && underrun_cnt != 16'hFFFF) begin
            underrun_cnt <= underrun_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_tmds_slot_scheduler.sv
// Directed bench for tmds_slot_scheduler with SLOT_LEN=10.
// Steps cycle by cycle and checks each slot load against hand values.
module tb_tmds_slot_scheduler;

    localparam int SLOT = 10;

    localparam logic [9:0] T00 = 10'b1101010100;
    localparam logic [9:0] T01 = 10'b0010101011;
    localparam logic [9:0] T10 = 10'b0101010100;
    localparam logic [9:0] T11 = 10'b1010101011;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       enable = 1'b0;
    logic [1:0] ctrl = 2'b00;
    logic       px_valid = 1'b0;
    logic [9:0] px_data = '0;
    logic       px_last = 1'b0;
    logic       px_ready;
    logic       aux_valid = 1'b0;
    logic [9:0] aux_data = '0;
    logic       aux_last = 1'b0;
    logic       aux_ready;
    logic [9:0] word;
    logic       word_load;
    logic [1:0] slot_src;
    logic       underrun;
    logic       underrun_clr = 1'b0;
`ifdef TMDS_SCHED_UNDERRUN_CNT_EN
    logic [15:0] underrun_cnt;
`endif

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int last_load = 0;
    logic got_pr, got_ar;

    tmds_slot_scheduler #(.SLOT_LEN(SLOT)) dut (
        .clk(clk),
        .rst(rst),
        .enable(enable),
        .ctrl(ctrl),
        .px_valid(px_valid),
        .px_data(px_data),
        .px_last(px_last),
        .px_ready(px_ready),
        .aux_valid(aux_valid),
        .aux_data(aux_data),
        .aux_last(aux_last),
        .aux_ready(aux_ready),
        .word(word),
        .word_load(word_load),
        .slot_src(slot_src),
        .underrun(underrun),
        .underrun_clr(underrun_clr)
`ifdef TMDS_SCHED_UNDERRUN_CNT_EN
        ,
        .underrun_cnt(underrun_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Advance to the next word_load, remembering the boundary-cycle readys.
    task automatic next_word(input string tag);
        int n;
        n = 0;
        got_pr = 1'b0;
        got_ar = 1'b0;
        do begin
            got_pr = px_ready;
            got_ar = aux_ready;
            tick();
            n++;
        end while (!word_load && n < 2 * SLOT);
        check({tag, "_load_seen"}, word_load, 1'b1);
        check({tag, "_gap"}, cyc - last_load, SLOT);
        last_load = cyc;
    endtask

    task automatic expect_word(input string tag, input logic [9:0] w,
                               input logic [1:0] s, input logic pr,
                               input logic ar);
        next_word(tag);
        check({tag, "_word"}, word, w);
        check({tag, "_src"}, slot_src, s);
        check({tag, "_pxrdy"}, got_pr, pr);
        check({tag, "_auxrdy"}, got_ar, ar);
    endtask

    initial begin
        tick();
        tick();
        check("rst_word", word, T00);
        check("rst_load", word_load, 1'b0);
        check("rst_src", slot_src, 2'b00);
        check("rst_ur", underrun, 1'b0);
        check("rst_rdy", {px_ready, aux_ready}, 2'b00);
        rst = 1'b1;
        last_load = cyc;

        // Idle: control tokens every slot
        enable = 1'b1;
        ctrl = 2'b10;
        expect_word("idle0", T10, 2'b00, 1'b0, 1'b0);
        tick();
        check("idle_pulse", word_load, 1'b0);
        ctrl = 2'b11;
        expect_word("idle1", T11, 2'b00, 1'b0, 1'b0);
        ctrl = 2'b01;

        // Pixel run of three words
        px_valid = 1'b1;
        px_data = 10'h155;
        expect_word("px0", 10'h155, 2'b01, 1'b1, 1'b0);
        px_data = 10'h2AA;
        expect_word("px1", 10'h2AA, 2'b01, 1'b1, 1'b0);
        px_data = 10'h3FF;
        px_last = 1'b1;
        expect_word("px2", 10'h3FF, 2'b01, 1'b1, 1'b0);
        px_valid = 1'b0;
        px_last = 1'b0;
        expect_word("px_end", T01, 2'b00, 1'b0, 1'b0);

        // Pixel beats aux; aux follows the run
        px_valid = 1'b1;
        px_data = 10'h001;
        aux_valid = 1'b1;
        aux_data = 10'h300;
        aux_last = 1'b1;
        expect_word("pri0", 10'h001, 2'b01, 1'b1, 1'b0);
        px_data = 10'h002;
        px_last = 1'b1;
        expect_word("pri1", 10'h002, 2'b01, 1'b1, 1'b0);
        px_valid = 1'b0;
        px_last = 1'b0;
        expect_word("pri_aux", 10'h300, 2'b10, 1'b0, 1'b1);
        aux_valid = 1'b0;
        aux_last = 1'b0;
        ctrl = 2'b00;
        expect_word("pri_end", T00, 2'b00, 1'b0, 1'b0);

        // Underrun after two words of a four-word run
        px_valid = 1'b1;
        px_data = 10'h011;
        expect_word("ur0", 10'h011, 2'b01, 1'b1, 1'b0);
        px_data = 10'h022;
        expect_word("ur1", 10'h022, 2'b01, 1'b1, 1'b0);
        check("ur_pre", underrun, 1'b0);
        px_valid = 1'b0;
        ctrl = 2'b11;
        expect_word("ur2", T11, 2'b00, 1'b1, 1'b0);
        check("ur_set", underrun, 1'b1);
`ifdef TMDS_SCHED_UNDERRUN_CNT_EN
        check("ur_cnt1", underrun_cnt, 16'd1);
`endif
        expect_word("ur_idle", T11, 2'b00, 1'b0, 1'b0);
        check("ur_sticky", underrun, 1'b1);
        px_valid = 1'b1;
        px_data = 10'h033;
        expect_word("ur3", 10'h033, 2'b01, 1'b1, 1'b0);
        px_valid = 1'b0;
        underrun_clr = 1'b1;
        expect_word("ur4", T11, 2'b00, 1'b1, 1'b0);
        check("ur_setwins", underrun, 1'b1);
`ifdef TMDS_SCHED_UNDERRUN_CNT_EN
        check("ur_cnt_clr_ev", underrun_cnt, 16'd1);
`endif
        tick();
        underrun_clr = 1'b0;
        check("ur_clr", underrun, 1'b0);
`ifdef TMDS_SCHED_UNDERRUN_CNT_EN
        check("ur_cnt0", underrun_cnt, 16'd0);
`endif

        // enable drops during a five-word aux packet
        ctrl = 2'b10;
        aux_valid = 1'b1;
        aux_data = 10'h101;
        expect_word("en0", 10'h101, 2'b10, 1'b0, 1'b1);
        enable = 1'b0;
        px_valid = 1'b1;
        px_data = 10'h0AA;
        for (int i = 2; i <= 5; i++) begin
            aux_data = 10'h100 + 10'(i);
            aux_last = (i == 5);
            expect_word($sformatf("en%0d", i - 1), 10'h100 + 10'(i),
                        2'b10, 1'b0, 1'b1);
        end
        aux_valid = 1'b0;
        aux_last = 1'b0;
        expect_word("en_off0", T10, 2'b00, 1'b0, 1'b0);
        expect_word("en_off1", T10, 2'b00, 1'b0, 1'b0);

        // Reset in the middle of the second pixel word
        enable = 1'b1;
        px_data = 10'h0F0;
        expect_word("rp0", 10'h0F0, 2'b01, 1'b1, 1'b0);
        px_data = 10'h0F1;
        expect_word("rp1", 10'h0F1, 2'b01, 1'b1, 1'b0);
        repeat (4) tick();
        #2 rst = 1'b0;
        #1;
        check("rp_word", word, T00);
        check("rp_src", slot_src, 2'b00);
        check("rp_rdy", {px_ready, aux_ready}, 2'b00);
        tick();
        tick();
        rst = 1'b1;
        last_load = cyc;
        px_data = 10'h0F0;
        expect_word("rp_restart", 10'h0F0, 2'b01, 1'b1, 1'b0);
        px_valid = 1'b0;
        expect_word("rp_video", T10, 2'b00, 1'b1, 1'b0);
        check("rp_ur", underrun, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
